i2c_target_regs: RTL and testbench

//  I2C target (responder) with an internal byte register file; the far end of the I2C master bus driven by cmd (SCL0/SDA0).

---
 rtl/i2c_tgt_pkg.sv | 30 +++
 rtl/i2c_tgt_line_cond.sv | 66 ++++++
 rtl/i2c_target_regs.sv | 200 ++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_tgt_pkg.sv
// Shared definitions for the I2C target register block.
//   tgt_state_t   : protocol FSM states, also exported on the debug state port
//   BIT_CNT_W     : width of the per-byte bit counter (counts 0..8)
//   I2C_RW_READ   : value of the R/W bit that selects a read transfer
//   is_rx_state() : states in which the target shifts bits in from SDA
package i2c_tgt_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_ADDR  = 4'd1,
    ST_ACK_A = 4'd2,
    ST_PTR   = 4'd3,
    ST_ACK_P = 4'd4,
    ST_WDATA = 4'd5,
    ST_ACK_W = 4'd6,
    ST_RDATA = 4'd7,
    ST_MACK  = 4'd8,
    ST_WAIT  = 4'd9
  } tgt_state_t;

  localparam int                    BIT_CNT_W     = 4;
  localparam logic [BIT_CNT_W-1:0]  BITS_PER_BYTE = 4'd8;
  localparam logic [BIT_CNT_W-1:0]  LAST_BIT      = 4'd7;
  localparam logic                  I2C_RW_READ   = 1'b1;

  function automatic logic is_rx_state(input tgt_state_t s);
    return (s == ST_ADDR) || (s == ST_PTR) || (s == ST_WDATA);
  endfunction

endpackage

// File: rtl/i2c_tgt_line_cond.sv
// Conditions one asynchronous I2C line (SCL or SDA) into the clk domain.
// Two-flop synchroniser, optional 3-tap majority filter, then edge detect.
// Configuration macro: I2C_TGT_GLITCH_FILTER_EN
//   defined   : majority filter enabled, pulses of 1 clk are rejected
//   undefined : no filter, every synchronised transition is an edge
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   i_line     : raw bus line
//   o_level    : conditioned line level
//   o_rise     : 1-cycle pulse on a conditioned 0->1 transition
//   o_fall     : 1-cycle pulse on a conditioned 1->0 transition
module i2c_tgt_line_cond (
  input  logic clk,
  input  logic rst_n,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_prev;
  logic w_cond;

  // Idle bus level is high; resetting to 1 avoids a false edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_line;
      r_s2 <= r_s1;
    end
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  logic [1:0] r_tap;
  logic       r_maj;

  // A single-cycle pulse occupies at most one of the three voting taps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tap <= 2'b11;
      r_maj <= 1'b1;
    end else begin
      r_tap <= {r_tap[0], r_s2};
      r_maj <= (r_s2 & r_tap[0]) | (r_tap[0] & r_tap[1]) | (r_s2 & r_tap[1]);
    end
  end

  assign w_cond = r_maj;
`else
  assign w_cond = r_s2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b1;
    else        r_prev <= w_cond;
  end

  assign o_level = w_cond;
  assign o_rise  = w_cond & ~r_prev;
  assign o_fall  = ~w_cond & r_prev;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with an internal byte register file. The master writes a register
// pointer followed by data bytes, or reads bytes back from the current pointer.
// SCL/SDA are oversampled in the clk domain; SCL is never stretched.
// Configuration macro: I2C_TGT_GLITCH_FILTER_EN (see i2c_tgt_line_cond).
// Handshake/timing: bits are sampled on conditioned SCL rise; sda_oe only changes
// on the cycle after a conditioned SCL fall (or immediately on START/STOP), so
// the target never moves SDA while SCL is high.
// Ports:
//   clk, rst_n  : system clock (>= 20x SCL), asynchronous active-low reset
//   scl_i/sda_i : asynchronous bus lines
//   sda_oe      : 1 = pull SDA low
//   regs_q      : register file, reg k at [8k+7:8k]
//   wr_stb      : 1-cycle pulse when a register write commits
//   wr_idx      : index written, valid with wr_stb
//   busy        : high from matched address ACK until STOP or mismatching restart
//   o_dbg_state : current FSM state (tgt_state_t encoding)
module i2c_target_regs
  import i2c_tgt_pkg::*;
#(
  parameter logic [6:0] TGT_ADDR = 7'h48,
  parameter int         NREG     = 16,
  parameter logic [7:0] RST_VAL  = 8'h00
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     scl_i,
  input  logic                     sda_i,
  output logic                     sda_oe,
  output logic [NREG*8-1:0]        regs_q,
  output logic                     wr_stb,
  output logic [$clog2(NREG)-1:0]  wr_idx,
  output logic                     busy,
  output logic [3:0]               o_dbg_state
);

  localparam int IDX_W = $clog2(NREG);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;

  i2c_tgt_line_cond u_scl (
    .clk(clk), .rst_n(rst_n), .i_line(scl_i),
    .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  i2c_tgt_line_cond u_sda (
    .clk(clk), .rst_n(rst_n), .i_line(sda_i),
    .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );

  tgt_state_t             r_state;
  tgt_state_t             w_state_nxt;
  logic [BIT_CNT_W-1:0]   r_cnt;
  logic [7:0]             r_rx;
  logic [7:0]             r_tx;
  logic [IDX_W-1:0]       r_ptr;
  logic [7:0]             r_regs [NREG];
  logic                   r_sda_oe;
  logic                   r_busy;
  logic                   r_wr_stb;
  logic [IDX_W-1:0]       r_wr_idx;
  logic                   r_mack_nack;

  logic                   w_start;
  logic                   w_stop;
  logic                   w_byte_done;
  logic                   w_last_rise;
  logic [7:0]             w_rx_byte;
  logic                   w_addr_match;
  logic                   w_enter_rdata;
  logic [7:0]             w_rd_byte;
  logic                   w_oe_nxt;

  assign w_start      = w_sda_fall & w_scl;
  assign w_stop       = w_sda_rise & w_scl;
  assign w_byte_done  = (r_cnt == BITS_PER_BYTE);
  assign w_last_rise  = w_scl_rise && (r_cnt == LAST_BIT);
  assign w_rx_byte    = {r_rx[6:0], w_sda};
  // Address 0 (general call) is never acknowledged.
  assign w_addr_match = (r_rx[7:1] == TGT_ADDR) && (r_rx[7:1] != 7'd0);
  assign w_rd_byte    = r_regs[r_ptr];
  assign w_enter_rdata = (w_state_nxt == ST_RDATA) && (r_state != ST_RDATA);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state. Byte boundaries advance on the SCL fall that follows the
  // 8th (or 9th) rise, so each state owns exactly the SCL low phases it drives.
  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = ST_ADDR;
    end else if (w_stop) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_ADDR:  if (w_scl_fall && w_byte_done)
                    w_state_nxt = w_addr_match ? ST_ACK_A : ST_WAIT;
        ST_ACK_A: if (w_scl_fall)
                    w_state_nxt = (r_rx[0] == I2C_RW_READ) ? ST_RDATA : ST_PTR;
        ST_PTR:   if (w_scl_fall && w_byte_done) w_state_nxt = ST_ACK_P;
        ST_ACK_P: if (w_scl_fall) w_state_nxt = ST_WDATA;
        ST_WDATA: if (w_scl_fall && w_byte_done) w_state_nxt = ST_ACK_W;
        ST_ACK_W: if (w_scl_fall) w_state_nxt = ST_WDATA;
        ST_RDATA: if (w_scl_fall && w_byte_done) w_state_nxt = ST_MACK;
        // r_cnt != 0 means the master's ACK bit has already been sampled.
        ST_MACK:  if (w_scl_fall && (r_cnt != '0))
                    w_state_nxt = r_mack_nack ? ST_WAIT : ST_RDATA;
        default:  w_state_nxt = r_state;
      endcase
    end
  end

  // FSM: output. SDA level the target wants for the low phase being entered.
  always_comb begin
    w_oe_nxt = 1'b0;
    case (w_state_nxt)
      ST_ACK_A, ST_ACK_P, ST_ACK_W: w_oe_nxt = 1'b1;
      ST_RDATA: w_oe_nxt = w_enter_rdata ? ~w_rd_byte[7] : ~r_tx[6];
      default:  w_oe_nxt = 1'b0;
    endcase
  end

  // Datapath: counters, shift registers, pointer, register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_ptr       <= '0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_stb    <= 1'b0;
      r_wr_idx    <= '0;
      r_mack_nack <= 1'b0;
      for (int k = 0; k < NREG; k++) r_regs[k] <= RST_VAL;
    end else begin
      r_wr_stb <= 1'b0;
      if (w_start || w_stop) begin
        // Release SDA at once, even if the master violated our drive phase.
        r_cnt    <= '0;
        r_sda_oe <= 1'b0;
        if (w_stop) r_busy <= 1'b0;
      end else begin
        if (w_state_nxt != r_state)
          r_cnt <= '0;
        else if (w_scl_rise && !w_byte_done)
          r_cnt <= r_cnt + BIT_CNT_W'(1);

        if (w_scl_rise && is_rx_state(r_state) && !w_byte_done)
          r_rx <= w_rx_byte;

        if (w_last_rise && (r_state == ST_PTR))
          r_ptr <= w_rx_byte[IDX_W-1:0];

        // Commit on the 8th rise, before the ACK.
        if (w_last_rise && (r_state == ST_WDATA)) begin
          r_regs[r_ptr] <= w_rx_byte;
          r_wr_stb      <= 1'b1;
          r_wr_idx      <= r_ptr;
          r_ptr         <= r_ptr + IDX_W'(1);
        end

        if (w_scl_rise && (r_state == ST_MACK))
          r_mack_nack <= w_sda;

        // The read byte is snapshotted here, so later writes cannot alter it.
        if (w_enter_rdata) begin
          r_tx  <= w_rd_byte;
          r_ptr <= r_ptr + IDX_W'(1);
        end else if (w_scl_fall && (r_state == ST_RDATA)) begin
          r_tx <= {r_tx[6:0], 1'b0};
        end

        if (w_scl_fall)
          r_sda_oe <= w_oe_nxt;

        if ((w_state_nxt == ST_ACK_A) && (r_state != ST_ACK_A))
          r_busy <= 1'b1;
        else if ((r_state == ST_ADDR) && (w_state_nxt == ST_WAIT))
          r_busy <= 1'b0;
      end
    end
  end

  always_comb begin
    regs_q = '0;
    for (int k = 0; k < NREG; k++) regs_q[8*k +: 8] = r_regs[k];
  end

  assign sda_oe      = r_sda_oe;
  assign wr_stb      = r_wr_stb;
  assign wr_idx      = r_wr_idx;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Self-checking bench for i2c_target_regs: a bit-banged I2C master, an
// open-drain SDA model, a register-file model and expected-value queues for
// register writes and read-back bytes.
module tb_i2c_target_regs;
  import i2c_tgt_pkg::*;

  localparam int Q = 10;  // clk cycles per quarter SCL period

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         m_scl;
  logic         m_sda;
  logic         scl_i;
  logic         sda_i;
  logic         sda_oe;
  logic [127:0] regs_q;
  logic         wr_stb;
  logic [3:0]   wr_idx;
  logic         busy;
  logic [3:0]   dbg_state;

  // Open-drain bus: either side may pull SDA low.
  assign scl_i = m_scl;
  assign sda_i = m_sda & ~sda_oe;

  i2c_target_regs dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl_i), .sda_i(sda_i),
    .sda_oe(sda_oe), .regs_q(regs_q), .wr_stb(wr_stb), .wr_idx(wr_idx),
    .busy(busy), .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [11:0] exp_q[$];     // {index, data} of each expected register write
  logic [7:0]  rd_exp_q[$];  // expected read-back bytes
  logic [7:0]  m_regs[16];
  logic [3:0]  m_ptr;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[8*k +: 8] = m_regs[k];
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst_n && wr_stb) begin
      if (exp_q.size() == 0) check("wr_unexpected", {wr_idx, regs_q[wr_idx*8 +: 8]}, 12'h000);
      else check("wr_stb", {wr_idx, regs_q[wr_idx*8 +: 8]}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic bus_restart();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; tick(Q);
    m_scl = 1'b1; tick(2*Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    b = sda_i; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  // glitch_at selects the bit (0 = MSB) whose low phase carries a 1-clk SCL pulse.
  task automatic write_byte(input logic [7:0] d, input int glitch_at, output logic acked);
    logic b;
    for (int i = 0; i < 8; i++) begin
      m_sda = d[7-i];
      if (i == glitch_at) begin
        tick(Q/2); m_scl = 1'b1; tick(1); m_scl = 1'b0; tick(Q/2);
      end else begin
        tick(Q);
      end
      m_scl = 1'b1; tick(2*Q);
      m_scl = 1'b0; tick(Q);
    end
    recv_bit(b);
    acked = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic give_ack);
    logic b;
    for (int i = 0; i < 8; i++) begin
      recv_bit(b);
      d[7-i] = b;
    end
    send_bit(~give_ack);
  endtask

  // Data byte the target must accept: model updated, write expectation queued.
  task automatic send_data(input string tag, input logic [7:0] d);
    logic acked;
    exp_q.push_back({m_ptr, d});
    m_regs[m_ptr] = d;
    m_ptr = m_ptr + 4'd1;
    write_byte(d, -1, acked);
    check(tag, acked, 1'b1);
  endtask

  task automatic send_ptr(input string tag, input logic [7:0] p);
    logic acked;
    m_ptr = p[3:0];
    write_byte(p, -1, acked);
    check(tag, acked, 1'b1);
  endtask

  task automatic send_addr(input string tag, input logic [7:0] a, input logic exp_ack);
    logic acked;
    write_byte(a, -1, acked);
    check(tag, acked, exp_ack);
  endtask

  task automatic read_check(input string tag, input logic give_ack);
    logic [7:0] d;
    rd_exp_q.push_back(m_regs[m_ptr]);
    m_ptr = m_ptr + 4'd1;
    read_byte(d, give_ack);
    check(tag, d, rd_exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic         acked;
    logic [127:0] snap;
    logic [7:0]   glitch_exp;
    logic         glitch_ack;

    for (int k = 0; k < 16; k++) m_regs[k] = 8'h00;
    m_ptr = 4'd0;
    m_scl = 1'b1;
    m_sda = 1'b1;
    rst_n = 1'b0;
    tick(3);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_regs", regs_q, model_flat());
    check("rst_wr_stb", wr_stb, 1'b0);
    check("rst_wr_idx", wr_idx, 4'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    tick(5);

    // 1: pointer 3, two data bytes.
    bus_start();
    send_addr("t1_addr_ack", 8'h90, 1'b1);
    check("t1_busy", busy, 1'b1);
    send_ptr("t1_ptr_ack", 8'h03);
    send_data("t1_d0_ack", 8'hA5);
    send_data("t1_d1_ack", 8'h5A);
    bus_stop();
    tick(4);
    check("t1_regs", regs_q, model_flat());
    check("t1_busy_after", busy, 1'b0);
    check("t1_state", dbg_state, ST_IDLE);

    // 2: fill 15,0,1 across the wrap (upper pointer bits ignored), then read back.
    bus_start();
    send_addr("t2_addr_ack", 8'h90, 1'b1);
    send_ptr("t2_ptr_ack", 8'hFF);
    for (int i = 0; i < 3; i++) send_data("t2_fill_ack", 8'($urandom_range(1, 127)));
    bus_stop();
    bus_start();
    send_addr("t2_waddr_ack", 8'h90, 1'b1);
    send_ptr("t2_rptr_ack", 8'h0F);
    bus_restart();
    send_addr("t2_raddr_ack", 8'h91, 1'b1);
    read_check("t2_rd15", 1'b1);
    read_check("t2_rd0", 1'b1);
    read_check("t2_rd1", 1'b0);
    check("t2_released", sda_oe, 1'b0);
    check("t2_state_wait", dbg_state, ST_WAIT);
    bus_stop();
    tick(4);

    // 3: wrong address is ignored until STOP.
    snap = model_flat();
    bus_start();
    send_addr("t3_addr_nack", 8'h92, 1'b0);
    check("t3_busy", busy, 1'b0);
    check("t3_state_wait", dbg_state, ST_WAIT);
    write_byte(8'h00, -1, acked);
    check("t3_data_nack", acked, 1'b0);
    bus_stop();
    tick(4);
    check("t3_regs", regs_q, snap);

    // 4: STOP after 4 bits of a data byte.
    bus_start();
    send_addr("t4_addr_ack", 8'h90, 1'b1);
    send_ptr("t4_ptr_ack", 8'h05);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    bus_stop();
    tick(4);
    check("t4_state", dbg_state, ST_IDLE);
    check("t4_sda_oe", sda_oe, 1'b0);
    check("t4_regs", regs_q, model_flat());

    // 5: reset while driving a 0 in RDATA (reg 1 has MSB 0).
    bus_start();
    send_addr("t5_addr_ack", 8'h90, 1'b1);
    send_ptr("t5_ptr_ack", 8'h01);
    bus_restart();
    send_addr("t5_raddr_ack", 8'h91, 1'b1);
    check("t5_state_rdata", dbg_state, ST_RDATA);
    check("t5_driving", sda_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_release", sda_oe, 1'b0);
    for (int k = 0; k < 16; k++) m_regs[k] = 8'h00;
    m_ptr = 4'd0;
    check("t5_rst_regs", regs_q, model_flat());
    m_scl = 1'b1;
    m_sda = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    bus_start();
    send_addr("t5_w_addr_ack", 8'h90, 1'b1);
    send_ptr("t5_w_ptr_ack", 8'h07);
    send_data("t5_w_data_ack", 8'hC3);
    bus_stop();
    tick(4);
    check("t5_regs", regs_q, model_flat());

    // 6: 1-clk SCL pulse in the low phase of bit 3 of 0xA5.
`ifdef I2C_TGT_GLITCH_FILTER_EN
    glitch_exp = 8'hA5;
    glitch_ack = 1'b1;
`else
    // Extra sampled bit: b7 b6 b5 b4 b4 b3 b2 b1; ACK lands one clock early.
    glitch_exp = 8'hA2;
    glitch_ack = 1'b0;
`endif
    bus_start();
    send_addr("t6_addr_ack", 8'h90, 1'b1);
    send_ptr("t6_ptr_ack", 8'h08);
    exp_q.push_back({m_ptr, glitch_exp});
    m_regs[m_ptr] = glitch_exp;
    m_ptr = m_ptr + 4'd1;
    write_byte(8'hA5, 3, acked);
    check("t6_ack", acked, glitch_ack);
    bus_stop();
    tick(4);
    check("t6_regs", regs_q, model_flat());
    check("t6_busy", busy, 1'b0);

    tick(10);
    check("wr_q_drained", exp_q.size(), 0);
    check("rd_q_drained", rd_exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
